// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and helpers: controller state, register-zero
// constant and the register-number compare used by every hazard check.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ABORT    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // $zero is hardwired, so a write to it never creates a dependency
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a == b) && (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard, flush and memory-freeze controller for the 5-stage MIPS pipeline.
// Performance counters are built only when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       rs_od5,
  input  logic [4:0]       rt_od5,
  input  logic             branch_od,
  input  logic             pc_src_od,
  input  logic [4:0]       write_reg_ex5,
  input  logic             enable_wreg_ex,
  input  logic             mem_to_reg_ex,
  input  logic [4:0]       write_reg_mem5,
  input  logic             mem_to_reg_mem,
  input  logic             dmem_req_i,
  input  logic             dmem_ack_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             freeze_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_e            state, state_d;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
  logic              ex_dep, mem_dep, lwstall, brstall, hz, freeze;

  // Dependencies of the Decode sources on the EX and MEM destinations
  assign ex_dep  = reg_match(write_reg_ex5, rs_od5)  || reg_match(write_reg_ex5, rt_od5);
  assign mem_dep = reg_match(write_reg_mem5, rs_od5) || reg_match(write_reg_mem5, rt_od5);
  assign lwstall = mem_to_reg_ex && ex_dep;
  assign brstall = branch_od && ((enable_wreg_ex && ex_dep) || (mem_to_reg_mem && mem_dep));
  assign hz      = lwstall || brstall;
  assign freeze  = (state == MEM_WAIT) ||
                   ((state == RUN) && dmem_req_i && !dmem_ack_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_cnt_d;
    end
  end

  // wait_cnt holds the number of cycles elapsed since the request cycle
  always_comb begin
    state_d    = state;
    wait_cnt_d = wait_cnt;
    case (state)
      RUN: begin
        if (dmem_req_i && !dmem_ack_i) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt + WAIT_W'(1);
          if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state_d = ABORT;
          end
        end
      end
      ABORT: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Reset flushes, freeze dominates, otherwise hazards win over a taken branch
  always_comb begin
    stall_if_o = 1'b0;
    stall_id_o = 1'b0;
    flush_id_o = 1'b0;
    flush_ex_o = 1'b0;
    freeze_o   = 1'b0;
    mem_err_o  = 1'b0;
    if (reset_i) begin
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end else if (freeze) begin
      freeze_o   = 1'b1;
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
    end else begin
      stall_if_o = hz;
      stall_id_o = hz;
      flush_ex_o = hz;
      flush_id_o = pc_src_od && !hz;
      mem_err_o  = (state == ABORT);
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc     (stall_id_o),
    .cnt     (stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc     (flush_id_o),
    .cnt     (flush_cnt_o)
  );
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a combinational vector table plus hand-written
// multi-cycle sequences (load-use, branch-on-load, memory wait, timeout, reset).
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 32;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       branch;
    logic       pc_src;
    logic [4:0] wr_ex;
    logic       en_wreg_ex;
    logic       m2r_ex;
    logic [4:0] wr_mem;
    logic       m2r_mem;
    logic       req;
    logic       ack;
  } in_t;

  // expected = {stall_if, stall_id, flush_id, flush_ex, freeze, mem_err}
  typedef struct packed {
    in_t        in;
    logic [5:0] exp;
  } vec_t;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [4:0]       rs_od5, rt_od5, write_reg_ex5, write_reg_mem5;
  logic             branch_od, pc_src_od, enable_wreg_ex, mem_to_reg_ex, mem_to_reg_mem;
  logic             dmem_req_i, dmem_ack_i;
  logic             stall_if_o, stall_id_o, flush_id_o, flush_ex_o, freeze_o, mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic             stall_if_4, stall_id_4, flush_id_4, flush_ex_4, freeze_4, mem_err_4;
  logic [CNT_W-1:0] stall_cnt_4, flush_cnt_4;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .rs_od5(rs_od5), .rt_od5(rt_od5),
    .branch_od(branch_od), .pc_src_od(pc_src_od), .write_reg_ex5(write_reg_ex5),
    .enable_wreg_ex(enable_wreg_ex), .mem_to_reg_ex(mem_to_reg_ex),
    .write_reg_mem5(write_reg_mem5), .mem_to_reg_mem(mem_to_reg_mem),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .flush_id_o(flush_id_o),
    .flush_ex_o(flush_ex_o), .freeze_o(freeze_o), .mem_err_o(mem_err_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut4 (
    .clk_i(clk_i), .reset_i(reset_i), .rs_od5(rs_od5), .rt_od5(rt_od5),
    .branch_od(branch_od), .pc_src_od(pc_src_od), .write_reg_ex5(write_reg_ex5),
    .enable_wreg_ex(enable_wreg_ex), .mem_to_reg_ex(mem_to_reg_ex),
    .write_reg_mem5(write_reg_mem5), .mem_to_reg_mem(mem_to_reg_mem),
    .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
    .stall_if_o(stall_if_4), .stall_id_o(stall_id_4), .flush_id_o(flush_id_4),
    .flush_ex_o(flush_ex_4), .freeze_o(freeze_4), .mem_err_o(mem_err_4),
    .stall_cnt_o(stall_cnt_4), .flush_cnt_o(flush_cnt_4)
  );

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt,
                             input logic br, input logic pcs,
                             input logic [4:0] wex, input logic enw, input logic m2rex,
                             input logic [4:0] wmem, input logic m2rmem,
                             input logic req, input logic ack);
    in_t v;
    v.rs = rs; v.rt = rt; v.branch = br; v.pc_src = pcs;
    v.wr_ex = wex; v.en_wreg_ex = enw; v.m2r_ex = m2rex;
    v.wr_mem = wmem; v.m2r_mem = m2rmem; v.req = req; v.ack = ack;
    return v;
  endfunction

  task automatic drive(input in_t v);
    rs_od5 = v.rs; rt_od5 = v.rt; branch_od = v.branch; pc_src_od = v.pc_src;
    write_reg_ex5 = v.wr_ex; enable_wreg_ex = v.en_wreg_ex; mem_to_reg_ex = v.m2r_ex;
    write_reg_mem5 = v.wr_mem; mem_to_reg_mem = v.m2r_mem;
    dmem_req_i = v.req; dmem_ack_i = v.ack;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check6(input string name, input logic [5:0] got, input logic [5:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (stall_if stall_id flush_id flush_ex freeze mem_err)",
               name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [CNT_W-1:0] got,
                           input logic [CNT_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {stall_if_o, stall_id_o, flush_id_o, flush_ex_o, freeze_o, mem_err_o};
  endfunction

  function automatic logic [5:0] outs4();
    return {stall_if_4, stall_id_4, flush_id_4, flush_ex_4, freeze_4, mem_err_4};
  endfunction

  // Apply inputs, let them settle mid-cycle, compare, then advance one edge
  task automatic step(input string name, input in_t v, input logic [5:0] exp);
    drive(v);
    #3;
    check6(name, outs(), exp);
    tick();
  endtask

  in_t  idle, lu, hz_only;
  vec_t vecs[14];
  logic [CNT_W-1:0] exp_stall_cnt;

  initial begin
    idle    = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    lu      = mk(5'd2, 5'd9, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    hz_only = lu;

    vecs[0]  = '{idle, 6'b000000};
    vecs[1]  = '{lu, 6'b110100};
    vecs[2]  = '{mk(5'd7, 5'd2, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), 6'b110100};
    vecs[3]  = '{mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), 6'b000000};
    vecs[4]  = '{mk(5'd3, 5'd4, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), 6'b000000};
    vecs[5]  = '{mk(5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0), 6'b001000};
    vecs[6]  = '{mk(5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 6'b110100};
    vecs[7]  = '{mk(5'd5, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0), 6'b110100};
    vecs[8]  = '{mk(5'd5, 5'd6, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0), 6'b000000};
    vecs[9]  = '{mk(5'd5, 5'd6, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0), 6'b000000};
    vecs[10] = '{mk(5'd5, 5'd6, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 6'b001000};
    vecs[11] = '{mk(5'd2, 5'd9, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1), 6'b110100};
    vecs[12] = '{mk(5'd0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0), 6'b001000};
    vecs[13] = '{mk(5'd5, 5'd6, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1), 6'b001000};

    // Reset: flushes asserted while held, counters cleared by the edge
    reset_i = 1'b1;
    drive(lu);
    #3;
    check6("reset_outs", outs(), 6'b001100);
    tick();
    #3;
    check6("reset_outs_after_edge", outs(), 6'b001100);
    check_cnt("reset_stall_cnt", stall_cnt_o, '0);
    check_cnt("reset_flush_cnt", flush_cnt_o, '0);
    reset_i = 1'b0;
    tick();

    for (int i = 0; i < 14; i++) begin
      step($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
    end

    // Load-use: one bubble, then lw has moved to MEM and Decode proceeds
    step("lu_c1", lu, 6'b110100);
    step("lu_c2", mk(5'd2, 5'd9, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0), 6'b000000);

    // Branch on a load in EX: two stalls, then the taken branch flushes IF/ID
    step("brld_c1", mk(5'd3, 5'd4, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), 6'b110100);
    step("brld_c2", mk(5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0), 6'b110100);
    step("brld_c3", mk(5'd3, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 6'b001000);
    step("brld_c4", idle, 6'b000000);

    // Memory wait with ack four cycles later; a load-use hazard is present throughout
    hz_only.pc_src = 1'b1;
    hz_only.req    = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      hz_only.ack = (c == 5);
      step($sformatf("memwait_c%0d", c), hz_only, 6'b110010);
    end
    step("memwait_after", idle, 6'b000000);

    // Watchdog on the MEM_TIMEOUT=4 instance: freeze 4 cycles, mem_err pulse in cycle 5
    for (int c = 1; c <= 5; c++) begin
      drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, (c < 5), 1'b0));
      #3;
      check6($sformatf("timeout_c%0d", c), outs4(), (c < 5) ? 6'b110010 : 6'b000001);
      tick();
    end
    drive(lu);
    #3;
    check6("timeout_back_to_run", outs4(), 6'b110100);
    tick();
    // release the long-timeout instance from its wait
    drive(mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1));
    tick();

    // Reset while in MEM_WAIT abandons the access
    step("rstwait_req", mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0),
         6'b110010);
    reset_i = 1'b1;
    step("rstwait_in_reset", idle, 6'b001100);
    reset_i = 1'b0;
    drive(lu);
    #3;
    check6("rstwait_run", outs(), 6'b110100);
    check_cnt("rstwait_stall_cnt", stall_cnt_o, '0);
    tick();
`ifdef HAZARD_CTRL_PERF_EN
    exp_stall_cnt = CNT_W'(1);
`else
    exp_stall_cnt = '0;
`endif
    drive(idle);
    #3;
    check_cnt("perf_stall_cnt", stall_cnt_o, exp_stall_cnt);
    check_cnt("perf_flush_cnt", flush_cnt_o, '0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
